// File: rtl/commit_monitor.sv
// End-of-test checker: waits for END_PC to commit HIT_COUNT times, then reads
// NUM_CHECKS registers one per cycle and reports sticky pass/fail with a watchdog.
module commit_monitor #(
  parameter int                      PC_WIDTH       = 32,
  parameter int                      DATA_WIDTH     = 32,
  parameter int                      REG_AW         = 5,
  parameter int                      NUM_CHECKS     = 4,
  parameter logic [PC_WIDTH-1:0]     END_PC         = 32'h1c000020,
  parameter int                      HIT_COUNT      = 1,
  parameter int                      TIMEOUT_CYCLES = 100000,
  parameter int                      CNT_W          = 32,
  localparam int                     IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           wb_valid,
  input  logic [PC_WIDTH-1:0]            wb_pc,
  input  logic [NUM_CHECKS-1:0]          exp_en,
  input  logic [NUM_CHECKS*REG_AW-1:0]   exp_idx,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] exp_val,
  output logic [REG_AW-1:0]              chk_raddr,
  input  logic [DATA_WIDTH-1:0]          chk_rdata,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic [1:0]                     fail_code,
  output logic [IDX_W-1:0]               fail_idx,
  output logic [DATA_WIDTH-1:0]          fail_data,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               commit_cnt
);

  localparam int HC_W = $clog2(HIT_COUNT + 1);
  localparam logic [HC_W-1:0]  HIT_LAST = HC_W'(HIT_COUNT - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_CHECKS - 1);
  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {RUN, CHECK, PASS, FAIL} state_t;

  state_t                state;
  logic [HC_W-1:0]       hit_cnt;
  logic [IDX_W-1:0]      chk_ptr;
  logic [REG_AW-1:0]     sel_idx;
  logic [DATA_WIDTH-1:0] sel_val;
  logic                  sel_en;
  logic                  end_hit;
  logic                  entry_ok;

  always_comb begin
    sel_idx = '0;
    sel_val = '0;
    sel_en  = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (chk_ptr == IDX_W'(i)) begin
        sel_idx = exp_idx[i*REG_AW +: REG_AW];
        sel_val = exp_val[i*DATA_WIDTH +: DATA_WIDTH];
        sel_en  = exp_en[i];
      end
    end
  end

  assign chk_raddr = (state == CHECK) ? sel_idx : '0;
  assign end_hit   = wb_valid && (wb_pc == END_PC);
  assign entry_ok  = !sel_en || (chk_rdata == sel_val);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= RUN;
      hit_cnt    <= '0;
      chk_ptr    <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= 2'd0;
      fail_idx   <= '0;
      fail_data  <= '0;
      cycle_cnt  <= '0;
      commit_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (wb_valid && (commit_cnt != '1))
            commit_cnt <= commit_cnt + CNT_W'(1);
          if (end_hit)
            hit_cnt <= hit_cnt + HC_W'(1);
          if (end_hit && (hit_cnt == HIT_LAST)) begin
            state   <= CHECK;
            chk_ptr <= '0;
            if (cycle_cnt != '1)
              cycle_cnt <= cycle_cnt + CNT_W'(1);
          end else if (cycle_cnt == TO_LAST) begin
            // cycle_cnt is left at TIMEOUT_CYCLES-1 so it names the expiring cycle
            state     <= FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_code <= CODE_TIMEOUT;
          end else if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          if (!entry_ok) begin
            state     <= FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_code <= CODE_MISMATCH;
            fail_idx  <= chk_ptr;
            fail_data <= chk_rdata;
          end else if (chk_ptr == PTR_LAST) begin
            state <= PASS;
            pass  <= 1'b1;
            done  <= 1'b1;
          end else begin
            chk_ptr <= chk_ptr + IDX_W'(1);
          end
        end
        PASS:    state <= PASS;
        FAIL:    state <= FAIL;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: two instances (HIT_COUNT 1 and 3) on a shared
// commit stream and a behavioural register file.
module tb_commit_monitor;

  localparam logic [31:0] END_PC = 32'h1c000020;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [1:0]  exp_en = 2'b11;
  logic [9:0]  exp_idx = {5'd5, 5'd12};
  logic [63:0] exp_val = {32'h5a, 32'h0f};
  logic [31:0] rf [32];

  logic [4:0]  a_raddr, b_raddr;
  logic [31:0] a_rdata, b_rdata;
  logic        a_done, a_pass, a_fail, b_done, b_pass, b_fail;
  logic [1:0]  a_code, b_code;
  logic        a_idx, b_idx;
  logic [31:0] a_data, b_data, a_cyc, b_cyc, a_com, b_com;

  assign a_rdata = rf[a_raddr];
  assign b_rdata = rf[b_raddr];

  always #5 clk = ~clk;

  commit_monitor #(.NUM_CHECKS(2), .END_PC(END_PC), .HIT_COUNT(1), .TIMEOUT_CYCLES(50)) u_a (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .exp_en(exp_en), .exp_idx(exp_idx), .exp_val(exp_val),
    .chk_raddr(a_raddr), .chk_rdata(a_rdata),
    .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
    .fail_idx(a_idx), .fail_data(a_data), .cycle_cnt(a_cyc), .commit_cnt(a_com));

  commit_monitor #(.NUM_CHECKS(2), .END_PC(END_PC), .HIT_COUNT(3), .TIMEOUT_CYCLES(1000)) u_b (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .exp_en(exp_en), .exp_idx(exp_idx), .exp_val(exp_val),
    .chk_raddr(b_raddr), .chk_rdata(b_rdata),
    .done(b_done), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
    .fail_idx(b_idx), .fail_data(b_data), .cycle_cnt(b_cyc), .commit_cnt(b_com));

  typedef struct {
    logic [1:0]  en;
    logic [31:0] r12;
    logic [31:0] r5;
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic        idx;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vecs [5];
  vec_t sb [$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wb_valid = 1'b0;
    wb_pc = '0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // nine commits 0x1c000000..0x1c000020, the last one being END_PC
  task automatic run_commits();
    for (int k = 0; k < 9; k++) begin
      wb_valid = 1'b1;
      wb_pc = 32'h1c000000 + 32'(k * 4);
      tick();
    end
    wb_valid = 1'b0;
    wb_pc = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog");
  end

  initial begin
    vec_t v;
    int lat;
    int n;
    logic [4:0] rec [4];

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    vecs[0] = '{en: 2'b11, r12: 32'h0f, r5: 32'h5a, pass: 1, fail: 0, code: 0, idx: 0, data: 0,        lat: 2};
    vecs[1] = '{en: 2'b11, r12: 32'h0f, r5: 32'h5b, pass: 0, fail: 1, code: 1, idx: 1, data: 32'h5b,   lat: 2};
    vecs[2] = '{en: 2'b01, r12: 32'h0f, r5: 32'h5b, pass: 1, fail: 0, code: 0, idx: 0, data: 0,        lat: 2};
    vecs[3] = '{en: 2'b11, r12: 32'h0e, r5: 32'h5a, pass: 0, fail: 1, code: 1, idx: 0, data: 32'h0e,   lat: 1};
    vecs[4] = '{en: 2'b10, r12: 32'h0e, r5: 32'h5a, pass: 1, fail: 0, code: 0, idx: 0, data: 0,        lat: 2};

    #1;
    check("reset_a_outputs", {a_done, a_pass, a_fail, a_code, a_idx, a_data, a_raddr}, 0);
    check("reset_a_counts", {a_cyc, a_com}, 0);
    check("reset_b_outputs", {b_done, b_pass, b_fail, b_code, b_idx, b_data, b_raddr}, 0);

    foreach (vecs[i]) begin
      rf[12] = vecs[i].r12;
      rf[5]  = vecs[i].r5;
      exp_en = vecs[i].en;
      sb.push_back(vecs[i]);
      do_reset();
      run_commits();
      lat = 0;
      while (!a_done && lat < 20) begin
        if (lat < 4) rec[lat] = a_raddr;
        tick();
        lat++;
      end
      v = sb.pop_front();
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(v.lat));
      check($sformatf("v%0d_status", i), {a_done, a_pass, a_fail, a_code}, {1'b1, v.pass, v.fail, v.code});
      check($sformatf("v%0d_fail_idx", i), 64'(a_idx), 64'(v.idx));
      check($sformatf("v%0d_fail_data", i), 64'(a_data), 64'(v.data));
      check($sformatf("v%0d_commit_cnt", i), 64'(a_com), 64'd9);
      check($sformatf("v%0d_cycle_cnt", i), 64'(a_cyc), 64'd9);
      for (int j = 0; j < v.lat && j < 4; j++)
        check($sformatf("v%0d_raddr%0d", i, j), 64'(rec[j]), (j == 0) ? 64'd12 : 64'd5);
    end

    rf[12] = 32'h0f;
    rf[5]  = 32'h5a;
    exp_en = 2'b11;

    // watchdog expiry with non-END commits every other cycle
    do_reset();
    n = 0;
    while (!a_done && n < 100) begin
      wb_valid = (n % 2 == 0);
      wb_pc = 32'h100;
      tick();
      n++;
    end
    wb_valid = 1'b0;
    check("to_cycles", 64'(n), 64'd50);
    check("to_status", {a_pass, a_fail, a_code}, {1'b0, 1'b1, 2'd2});
    check("to_cycle_cnt", 64'(a_cyc), 64'd49);
    check("to_commit_cnt", 64'(a_com), 64'd25);
    repeat (3) tick();
    check("to_sticky", {a_done, a_pass, a_fail, a_code}, {1'b1, 1'b0, 1'b1, 2'd2});

    // END_PC lands in the very cycle the watchdog would expire
    do_reset();
    repeat (49) tick();
    wb_valid = 1'b1;
    wb_pc = END_PC;
    tick();
    wb_valid = 1'b0;
    check("hit_vs_to_nofail", {a_done, a_fail}, 2'b00);
    check("hit_vs_to_raddr", 64'(a_raddr), 64'd12);
    tick();
    tick();
    check("hit_vs_to_pass", {a_done, a_pass, a_fail, a_code}, {1'b1, 1'b1, 1'b0, 2'd0});

    // asynchronous reset while in CHECK, then a clean rerun
    do_reset();
    run_commits();
    tick();
    check("midchk_pre", {a_done, a_raddr}, {1'b0, 5'd5});
    resetn = 1'b0;
    #1;
    check("midchk_outputs", {a_done, a_pass, a_fail, a_code, a_idx, a_data, a_raddr}, 0);
    check("midchk_counts", {a_cyc, a_com}, 0);
    do_reset();
    run_commits();
    tick();
    tick();
    check("rerun_pass", {a_done, a_pass, a_fail, a_code}, {1'b1, 1'b1, 1'b0, 2'd0});

    // HIT_COUNT=3: CHECK only after the third END_PC commit
    do_reset();
    for (int r = 0; r < 3; r++) begin
      run_commits();
      if (r < 2) begin
        check($sformatf("hit3_rep%0d_run", r), {b_done, b_raddr}, 0);
        tick();
      end else begin
        check("hit3_check_raddr", 64'(b_raddr), 64'd12);
      end
    end
    tick();
    check("hit3_not_done", 64'(b_done), 64'd0);
    tick();
    check("hit3_pass", {b_done, b_pass, b_fail, b_code}, {1'b1, 1'b1, 1'b0, 2'd0});
    check("hit3_commit_cnt", 64'(b_com), 64'd27);
    check("hit3_cycle_cnt", 64'(b_cyc), 64'd29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
